// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
package uart_pkg;

   localparam int unsigned UART_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      START,
      WAIT_DONE
   } arb_state_e;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned res;
      int unsigned v;
      res = 0;
      v   = (value > 0) ? value - 1 : 0;
      while (v > 0) begin
         res = res + 1;
         v   = v >> 1;
      end
      return res;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Producer-side byte handshake plus the uart_tx start/busy pair, bundled for the arbiter.
interface uart_tx_arbiter_if #(
   parameter int unsigned NUM_REQ = 4
);
   import uart_pkg::*;

   localparam int unsigned IDX_W = clog2(NUM_REQ);

   logic [NUM_REQ-1:0]             req_valid;
   logic [UART_DATA_W*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]             req_last;
   logic [NUM_REQ-1:0]             req_ready;
   logic [IDX_W-1:0]               grant_id;
   logic                           locked;
   logic                           tx_start;
   logic [UART_DATA_W-1:0]         tx_data;
   logic                           tx_busy;
   logic                           timeout_err;

   modport master (
      output req_valid, req_data, req_last, tx_busy,
      input  req_ready, grant_id, locked, tx_start, tx_data, timeout_err
   );

   modport slave (
      input  req_valid, req_data, req_last, tx_busy,
      output req_ready, grant_id, locked, tx_start, tx_data, timeout_err
   );

endinterface

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo N.
module rr_picker #(
   parameter int unsigned N     = 4,
   parameter int unsigned IDX_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] idx,
   output logic             gnt_valid
);

   int unsigned j;

   always_comb begin
      gnt       = '0;
      idx       = '0;
      gnt_valid = 1'b0;
      j         = 0;
      for (int unsigned k = 0; k < N; k++) begin
         j = (32'(ptr) + k) % N;
         if (!gnt_valid && req[j]) begin
            gnt_valid = 1'b1;
            gnt[j]    = 1'b1;
            idx       = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ byte producers,
// holding the grant for the length of a multi-byte message.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int unsigned NUM_REQ      = 4,
   parameter int unsigned BUSY_TIMEOUT = 1024
) (
   input  logic             clk,
   input  logic             rst,
   uart_tx_arbiter_if.slave bus
);

   localparam int unsigned      IDX_W    = clog2(NUM_REQ);
   localparam int unsigned      CNT_W    = clog2(BUSY_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

   arb_state_e             state_q, state_d;
   logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]       grant_id_q, grant_id_d;
   logic                   locked_q, locked_d;
   logic                   timeout_err_q, timeout_err_d;
   logic [UART_DATA_W-1:0] tx_data_q, tx_data_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;

   logic [NUM_REQ-1:0]     pick_gnt;
   logic [IDX_W-1:0]       pick_idx;
   logic                   pick_valid;
   logic [NUM_REQ-1:0]     ready_c;
   logic [IDX_W-1:0]       win_idx;
   logic                   win;

   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
      return (32'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
   endfunction

   rr_picker #(
      .N     (NUM_REQ),
      .IDX_W (IDX_W)
   ) u_picker (
      .req       (bus.req_valid),
      .ptr       (rr_ptr_q),
      .gnt       (pick_gnt),
      .idx       (pick_idx),
      .gnt_valid (pick_valid)
   );

   always_comb begin
      state_d       = state_q;
      rr_ptr_d      = rr_ptr_q;
      grant_id_d    = grant_id_q;
      locked_d      = locked_q;
      tx_data_d     = tx_data_q;
      cnt_d         = '0;
      timeout_err_d = 1'b0;
      ready_c       = '0;
      win           = 1'b0;
      win_idx       = grant_id_q;

      unique case (state_q)
         IDLE: begin
            // Never grant over a running frame, including one left over from a reset.
            if (!bus.tx_busy) begin
               if (locked_q) begin
                  win                 = bus.req_valid[grant_id_q];
                  ready_c[grant_id_q] = win;
               end else begin
                  win     = pick_valid;
                  win_idx = pick_idx;
                  ready_c = pick_gnt;
               end
            end
            if (win) begin
               tx_data_d  = bus.req_data[UART_DATA_W*win_idx +: UART_DATA_W];
               grant_id_d = win_idx;
               state_d    = START;
               if (bus.req_last[win_idx]) begin
                  locked_d = 1'b0;
                  rr_ptr_d = next_idx(win_idx);
               end else begin
                  locked_d = 1'b1;
               end
            end
         end

         START: begin
            // Busy is checked first so it wins over an expiry in the same cycle.
            if (bus.tx_busy) begin
               state_d = WAIT_DONE;
            end else if (cnt_q == CNT_LAST) begin
               timeout_err_d = 1'b1;
               locked_d      = 1'b0;
               rr_ptr_d      = next_idx(grant_id_q);
               state_d       = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         WAIT_DONE: begin
            if (!bus.tx_busy) begin
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         rr_ptr_q      <= '0;
         grant_id_q    <= '0;
         locked_q      <= 1'b0;
         timeout_err_q <= 1'b0;
         tx_data_q     <= '0;
         cnt_q         <= '0;
      end else begin
         state_q       <= state_d;
         rr_ptr_q      <= rr_ptr_d;
         grant_id_q    <= grant_id_d;
         locked_q      <= locked_d;
         timeout_err_q <= timeout_err_d;
         tx_data_q     <= tx_data_d;
         cnt_q         <= cnt_d;
      end
   end

   assign bus.req_ready   = rst ? '0 : ready_c;
   assign bus.grant_id    = grant_id_q;
   assign bus.locked      = locked_q;
   assign bus.tx_start    = (state_q == START);
   assign bus.tx_data     = tx_data_q;
   assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: vector table for grant order and locking,
// hand-written sequences for timeout, busy-vs-expiry and reset mid-frame.
module tb_uart_tx_arbiter;
   import uart_pkg::*;

   localparam int NV = 12;

   typedef struct packed {
      logic [3:0]  valid;
      logic [3:0]  last;
      logic [31:0] data;
      logic [3:0]  exp_ready;
      logic [7:0]  exp_byte;
      logic [1:0]  exp_grant;
      logic        exp_locked;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   logic model_en;
   logic model_busy = 1'b0;
   logic man_busy;
   int   busy_delay;
   int   busy_len;
   int   m_phase = 0;
   int   m_cnt = 0;
   int   checks = 0;
   int   errors = 0;
   vec_t vecs [NV];

   uart_tx_arbiter_if #(.NUM_REQ(4)) bus ();

   uart_tx_arbiter #(
      .NUM_REQ      (4),
      .BUSY_TIMEOUT (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   assign bus.tx_busy = model_en ? model_busy : man_busy;

   // uart_tx stand-in: busy rises busy_delay cycles after tx_start, stays busy_len cycles.
   always begin
      @(posedge clk);
      #1;
      if (!model_en) begin
         m_phase    = 0;
         model_busy = 1'b0;
      end else begin
         case (m_phase)
            0: if (bus.tx_start) begin m_phase = 1; m_cnt = 0; end
            1: begin
               m_cnt++;
               if (m_cnt == busy_delay) begin model_busy = 1'b1; m_cnt = 0; m_phase = 2; end
            end
            default: begin
               m_cnt++;
               if (m_cnt == busy_len) begin model_busy = 1'b0; m_phase = 0; end
            end
         endcase
      end
   end

   always @(negedge clk) begin
      if (!rst && (bus.tx_busy || dut.state_q != IDLE)) begin
         checks++;
         if (bus.req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL ready_while_busy: got 0x%0h expected 0x0 at %0t", bus.req_ready, $time);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (!(dut.state_q == IDLE && !bus.tx_busy) && n < 300) begin
         @(posedge clk);
         @(negedge clk);
         n++;
      end
      check("idle_wait_bound", 32'(n < 300), 32'd1);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_tx_start"}, 32'(bus.tx_start), 32'd0);
      check({tag, "_tx_data"}, 32'(bus.tx_data), 32'd0);
      check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
      check({tag, "_grant_id"}, 32'(bus.grant_id), 32'd0);
      check({tag, "_locked"}, 32'(bus.locked), 32'd0);
      check({tag, "_timeout_err"}, 32'(bus.timeout_err), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic seen;

      // Rotation from rr_ptr=0, then a locked 3-byte message from req2 while req0 waits.
      vecs[0]  = '{4'hF, 4'hF, 32'h13121110, 4'b0001, 8'h10, 2'd0, 1'b0};
      vecs[1]  = '{4'hF, 4'hF, 32'h13121110, 4'b0010, 8'h11, 2'd1, 1'b0};
      vecs[2]  = '{4'hF, 4'hF, 32'h13121110, 4'b0100, 8'h12, 2'd2, 1'b0};
      vecs[3]  = '{4'hF, 4'hF, 32'h13121110, 4'b1000, 8'h13, 2'd3, 1'b0};
      vecs[4]  = '{4'hF, 4'hF, 32'h13121110, 4'b0001, 8'h10, 2'd0, 1'b0};
      vecs[5]  = '{4'b0101, 4'b0000, 32'h00A00055, 4'b0100, 8'hA0, 2'd2, 1'b1};
      vecs[6]  = '{4'b0101, 4'b0000, 32'h00A10055, 4'b0100, 8'hA1, 2'd2, 1'b1};
      vecs[7]  = '{4'b0101, 4'b0100, 32'h00A20055, 4'b0100, 8'hA2, 2'd2, 1'b0};
      vecs[8]  = '{4'b0001, 4'b0001, 32'h00000055, 4'b0001, 8'h55, 2'd0, 1'b0};
      vecs[9]  = '{4'b0101, 4'b0000, 32'h00B00066, 4'b0100, 8'hB0, 2'd2, 1'b1};
      vecs[10] = '{4'b0101, 4'b0100, 32'h00B10066, 4'b0100, 8'hB1, 2'd2, 1'b0};
      vecs[11] = '{4'b1001, 4'b1001, 32'h77000066, 4'b1000, 8'h77, 2'd3, 1'b0};

      rst           = 1'b1;
      model_en      = 1'b1;
      man_busy      = 1'b0;
      busy_delay    = 2;
      busy_len      = 20;
      bus.req_valid = '0;
      bus.req_last  = '0;
      bus.req_data  = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_values("rst");

      // Basic accept and send from requester 1.
      @(posedge clk); #1;
      rst           = 1'b0;
      bus.req_valid = 4'b0010;
      bus.req_last  = 4'b0010;
      bus.req_data  = 32'h00004100;
      @(negedge clk);
      check("t1_ready_c0", 32'(bus.req_ready), 32'h2);
      check("t1_start_c0", 32'(bus.tx_start), 32'd0);
      @(posedge clk); #1;
      bus.req_valid = '0;
      @(negedge clk);
      check("t1_start_c1", 32'(bus.tx_start), 32'd1);
      check("t1_data", 32'(bus.tx_data), 32'h41);
      check("t1_grant", 32'(bus.grant_id), 32'd1);
      check("t1_locked", 32'(bus.locked), 32'd0);
      check("t1_rr_ptr", 32'(dut.rr_ptr_q), 32'd2);
      wait_idle();

      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      busy_len = 6;

      for (int i = 0; i < NV; i++) begin
         @(posedge clk); #1;
         bus.req_valid = vecs[i].valid;
         bus.req_last  = vecs[i].last;
         bus.req_data  = vecs[i].data;
         @(negedge clk);
         check($sformatf("v%0d_ready", i), 32'(bus.req_ready), 32'(vecs[i].exp_ready));
         @(posedge clk); #1;
         bus.req_valid = '0;
         @(negedge clk);
         check($sformatf("v%0d_start", i), 32'(bus.tx_start), 32'd1);
         check($sformatf("v%0d_data", i), 32'(bus.tx_data), 32'(vecs[i].exp_byte));
         check($sformatf("v%0d_grant", i), 32'(bus.grant_id), 32'(vecs[i].exp_grant));
         check($sformatf("v%0d_locked", i), 32'(bus.locked), 32'(vecs[i].exp_locked));
         wait_idle();
      end

      // Busy timeout: serializer never answers; rr_ptr is 0 here.
      model_en = 1'b0;
      man_busy = 1'b0;
      @(posedge clk); #1;
      bus.req_valid = 4'b0001;
      bus.req_last  = 4'b0000;
      bus.req_data  = 32'h00000088;
      @(negedge clk);
      check("t4_ready", 32'(bus.req_ready), 32'h1);
      @(posedge clk); #1;
      bus.req_valid = '0;
      @(negedge clk);
      check("t4_start", 32'(bus.tx_start), 32'd1);
      check("t4_locked", 32'(bus.locked), 32'd1);
      n = 0;
      while (!bus.timeout_err && n < 40) begin
         @(posedge clk);
         @(negedge clk);
         n++;
      end
      check("t4_err_latency", 32'(n), 32'd16);
      check("t4_start_drop", 32'(bus.tx_start), 32'd0);
      check("t4_unlock", 32'(bus.locked), 32'd0);
      @(posedge clk); #1;
      model_en      = 1'b1;
      bus.req_valid = 4'b0011;
      bus.req_last  = 4'b0011;
      bus.req_data  = 32'h00009988;
      @(negedge clk);
      check("t4_err_pulse", 32'(bus.timeout_err), 32'd0);
      check("t4_next_ready", 32'(bus.req_ready), 32'h2);
      @(posedge clk); #1;
      bus.req_valid = '0;
      @(negedge clk);
      check("t4_next_data", 32'(bus.tx_data), 32'h99);
      wait_idle();

      // Busy rises in the very cycle the count expires.
      busy_delay = 15;
      @(posedge clk); #1;
      bus.req_valid = 4'b0001;
      bus.req_last  = 4'b0001;
      bus.req_data  = 32'h000000AB;
      @(negedge clk);
      check("t6_ready", 32'(bus.req_ready), 32'h1);
      @(posedge clk); #1;
      bus.req_valid = '0;
      @(negedge clk);
      n    = 0;
      seen = 1'b0;
      while (bus.tx_start && n < 40) begin
         n++;
         @(posedge clk);
         @(negedge clk);
         if (bus.timeout_err) seen = 1'b1;
      end
      check("t6_start_cycles", 32'(n), 32'd16);
      check("t6_no_err", 32'(seen), 32'd0);
      check("t6_state", 32'(dut.state_q), 32'(WAIT_DONE));
      wait_idle();
      busy_delay = 2;

      // Reset while WAIT_DONE with the serializer still busy.
      model_en = 1'b0;
      man_busy = 1'b0;
      @(posedge clk); #1;
      bus.req_valid = 4'b0100;
      bus.req_last  = 4'b0000;
      bus.req_data  = 32'h00C00000;
      @(negedge clk);
      check("t5_ready", 32'(bus.req_ready), 32'h4);
      @(posedge clk); #1;
      bus.req_valid = '0;
      man_busy      = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("t5_state_pre", 32'(dut.state_q), 32'(WAIT_DONE));
      check("t5_locked_pre", 32'(bus.locked), 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_reset_values("t5");
      @(posedge clk); #1;
      rst           = 1'b0;
      bus.req_valid = 4'b0001;
      bus.req_last  = 4'b0001;
      bus.req_data  = 32'h000000D1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         check("t5_hold_ready", 32'(bus.req_ready), 32'd0);
         @(posedge clk); #1;
      end
      man_busy = 1'b0;
      @(negedge clk);
      check("t5_ready_after_busy", 32'(bus.req_ready), 32'h1);
      @(posedge clk); #1;
      bus.req_valid = '0;
      @(negedge clk);
      check("t5_data_after", 32'(bus.tx_data), 32'hD1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
